// File: rtl/glay_setup_resp_unpacker_pkg.sv
// Shared FSM state encoding and line geometry for the setup-response unpacker.
// Default geometry is a 512-bit cacheline split into 32-bit words.
package glay_setup_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_DATA_WIDTH    = 512;
    localparam int DEF_WORD_WIDTH    = 32;
    localparam int DEF_COUNTER_WIDTH = 32;
    localparam int WORDS_PER_LINE    = DEF_DATA_WIDTH / DEF_WORD_WIDTH;

    function automatic int words_per_line(input int data_width, input int word_width);
        return data_width / word_width;
    endfunction

endpackage

// File: rtl/glay_setup_resp_unpacker_if.sv
// Cacheline-in / word-out stream bundle; master drives lines and takes words,
// slave (the unpacker) takes lines and drives words.
interface glay_setup_resp_unpacker_if #(
    parameter int DATA_WIDTH    = 512,
    parameter int WORD_WIDTH    = 32,
    parameter int COUNTER_WIDTH = 32
);
    logic                     resp_in_valid;
    logic [DATA_WIDTH-1:0]    resp_in_data;
    logic                     resp_in_ready;
    logic                     word_out_valid;
    logic [WORD_WIDTH-1:0]    word_out_data;
    logic [COUNTER_WIDTH-1:0] word_out_index;
    logic                     word_out_ready;

    modport master (
        output resp_in_valid, resp_in_data, word_out_ready,
        input  resp_in_ready, word_out_valid, word_out_data, word_out_index
    );

    modport slave (
        input  resp_in_valid, resp_in_data, word_out_ready,
        output resp_in_ready, word_out_valid, word_out_data, word_out_index
    );
endinterface

// File: rtl/glay_setup_resp_unpacker.sv
// Unpacks setup-response cachelines into a counted word stream; first word one cycle after a line handshake.
// Backpressure: word_out_ready low freezes the current word; resp_in_ready is asserted only in LOAD.
module glay_setup_resp_unpacker
    import glay_setup_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     start,
    input  logic [COUNTER_WIDTH-1:0] word_count,
    output logic                     busy,
    output logic                     done,
    glay_setup_resp_unpacker_if.slave bus
);

    localparam int WPL    = words_per_line(DATA_WIDTH, WORD_WIDTH);
    localparam int LANE_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WPL - 1);

    state_e                            state_q, state_d;
    logic [COUNTER_WIDTH-1:0]          count_q, count_d;
    logic [COUNTER_WIDTH-1:0]          index_q, index_d;
    logic [LANE_W-1:0]                 lane_q, lane_d;
    logic [WPL-1:0][WORD_WIDTH-1:0]    line_q, line_d;
    logic                              last_word;

    // Compare one bit wider so a count of 2^COUNTER_WIDTH-1 terminates without wrap.
    assign last_word = ((COUNTER_WIDTH+1)'(index_q) + (COUNTER_WIDTH+1)'(1))
                       == (COUNTER_WIDTH+1)'(count_q);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            count_q <= '0;
            index_q <= '0;
            lane_q  <= '0;
            line_q  <= '0;
        end else begin
            count_q <= count_d;
            index_q <= index_d;
            lane_q  <= lane_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        lane_d  = lane_q;
        line_d  = line_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (word_count != '0) begin
                        count_d = word_count;
                        index_d = '0;
                        lane_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.resp_in_valid) begin
                    line_d  = bus.resp_in_data;
                    lane_d  = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.word_out_ready) begin
                    if (last_word) begin
                        // Remaining lanes of a partially used line are simply dropped.
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + COUNTER_WIDTH'(1);
                        if (lane_q == LAST_LANE) begin
                            state_d = ST_LOAD;
                        end else begin
                            lane_d = lane_q + LANE_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.resp_in_ready  = (state_q == ST_LOAD);
    assign bus.word_out_valid = (state_q == ST_SHIFT);
    assign bus.word_out_data  = line_q[lane_q];
    assign bus.word_out_index = index_q;
    assign busy               = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    assign done               = (state_q == ST_DONE);

endmodule

// File: tb/tb_glay_setup_resp_unpacker.sv
// Directed and randomized jobs against a queue-based model: word k of a job is lane k%WPL
// of the k/WPL-th accepted line, emitted with index k.
module tb_glay_setup_resp_unpacker;
    import glay_setup_pkg::*;

    localparam int DW  = DEF_DATA_WIDTH;
    localparam int WW  = DEF_WORD_WIDTH;
    localparam int CW  = DEF_COUNTER_WIDTH;
    localparam int WPL = WORDS_PER_LINE;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          start;
    logic [CW-1:0] word_count;
    logic          busy;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] lines[$];

    glay_setup_resp_unpacker_if #(.DATA_WIDTH(DW), .WORD_WIDTH(WW), .COUNTER_WIDTH(CW)) bus ();

    glay_setup_resp_unpacker #(.DATA_WIDTH(DW), .WORD_WIDTH(WW), .COUNTER_WIDTH(CW)) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .start      (start),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] make_line(input bit counting, input int line_no);
        logic [DW-1:0] l;
        for (int j = 0; j < WPL; j++) begin
            l[j*WW +: WW] = counting ? WW'(line_no * WPL + j) : WW'($urandom);
        end
        return l;
    endfunction

    // Caller is at a falling edge. rmode: 0 ready always, 1 toggling, 2 random.
    task automatic run_job(input int n, input int rmode, input int vdelay, input bit counting,
                           input int poke_at, input int abort_at);
        int            words, cyc, lines_hs, needed, wait_cyc;
        bit            loaded_prev, waiting_prev, rdy;
        logic [DW-1:0] nxt, l;
        logic [WW-1:0] exp_word;

        lines.delete();
        needed       = (n + WPL - 1) / WPL;
        nxt          = make_line(counting, 0);
        words        = 0;
        cyc          = 0;
        lines_hs     = 0;
        wait_cyc     = 0;
        loaded_prev  = 0;
        waiting_prev = 0;
        start        = 1'b1;
        word_count   = CW'(n);

        while (1) begin
            @(negedge ap_clk);
            start = 1'b0;
            if (words == n) break;
            cyc++;
            if (cyc > 3000) begin
                check("timeout_words", 64'(words), 64'(n));
                break;
            end
            check("busy_high", 64'(busy), 64'(1));
            check("done_low", 64'(done), 64'(0));
            if (loaded_prev)  check("first_word_latency", 64'(bus.word_out_valid), 64'(1));
            if (waiting_prev) check("ready_held", 64'(bus.resp_in_ready), 64'(1));
            loaded_prev  = 0;
            waiting_prev = 0;

            if (bus.resp_in_ready) begin
                check("load_no_word", 64'(bus.word_out_valid), 64'(0));
                check("no_extra_line", 64'(lines_hs < needed), 64'(1));
                if (wait_cyc >= vdelay) begin
                    bus.resp_in_valid = 1'b1;
                    bus.resp_in_data  = nxt;
                    lines.push_back(nxt);
                    lines_hs++;
                    loaded_prev = 1;
                    wait_cyc    = 0;
                    nxt         = make_line(counting, lines_hs);
                end else begin
                    bus.resp_in_valid = 1'b0;
                    bus.resp_in_data  = make_line(1'b0, 0);
                    wait_cyc++;
                    waiting_prev = 1;
                end
            end else begin
                // Garbage outside LOAD must never be captured.
                bus.resp_in_valid = 1'($urandom_range(0, 1));
                bus.resp_in_data  = make_line(1'b0, 0);
            end

            if (bus.word_out_valid) begin
                check("line_available", 64'(lines.size() > words / WPL), 64'(1));
                if (lines.size() > words / WPL) begin
                    l        = lines[words / WPL];
                    exp_word = l[(words % WPL) * WW +: WW];
                    check("word_data", 64'(bus.word_out_data), 64'(exp_word));
                end
                check("word_index", 64'(bus.word_out_index), 64'(words));
                case (rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'(cyc % 2);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                bus.word_out_ready = rdy;
                if (words == abort_at) begin
                    ap_rst_n = 1'b0;
                    start    = 1'b0;
                    bus.resp_in_valid = 1'b0;
                    #1;
                    check("rst_ready", 64'(bus.resp_in_ready), 64'(0));
                    check("rst_valid", 64'(bus.word_out_valid), 64'(0));
                    check("rst_busy", 64'(busy), 64'(0));
                    check("rst_done", 64'(done), 64'(0));
                    check("rst_data", 64'(bus.word_out_data), 64'(0));
                    check("rst_index", 64'(bus.word_out_index), 64'(0));
                    @(negedge ap_clk);
                    ap_rst_n = 1'b1;
                    return;
                end
                if (rdy) words++;
            end else begin
                bus.word_out_ready = 1'($urandom_range(0, 1));
            end

            if (cyc == poke_at) begin
                start      = 1'b1;
                word_count = CW'($urandom_range(1, 100));
            end
        end

        check("done_high", 64'(done), 64'(1));
        check("busy_low", 64'(busy), 64'(0));
        check("ready_low_end", 64'(bus.resp_in_ready), 64'(0));
        check("valid_low_end", 64'(bus.word_out_valid), 64'(0));
        check("line_handshakes", 64'(lines_hs), 64'(needed));
        if (rmode == 0 && vdelay == 0) check("job_cycles", 64'(cyc), 64'(n + needed));
        bus.resp_in_valid = 1'b0;
    endtask

    initial begin
        ap_rst_n           = 1'b0;
        start              = 1'b0;
        word_count         = '0;
        bus.resp_in_valid  = 1'b0;
        bus.resp_in_data   = '0;
        bus.word_out_ready = 1'b0;
        repeat (3) @(negedge ap_clk);
        check("reset_ready", 64'(bus.resp_in_ready), 64'(0));
        check("reset_valid", 64'(bus.word_out_valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_data", 64'(bus.word_out_data), 64'(0));
        check("reset_index", 64'(bus.word_out_index), 64'(0));
        ap_rst_n = 1'b1;

        run_job(0, 0, 0, 1'b0, -1, -1);
        run_job(20, 0, 0, 1'b1, -1, -1);
        run_job(16, 1, 0, 1'b0, -1, -1);
        run_job(5, 2, 10, 1'b0, -1, -1);
        run_job(12, 2, 1, 1'b0, 4, -1);
        run_job(5, 0, 0, 1'b1, -1, -1);
        run_job(32, 2, 0, 1'b0, -1, 7);
        run_job(3, 0, 0, 1'b0, -1, -1);
        for (int t = 0; t < 6; t++) begin
            run_job($urandom_range(1, 40), $urandom_range(0, 2), $urandom_range(0, 3),
                    1'b0, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/glay_setup_resp_unpacker.md
GLAY_SETUP_RESP_UNPACKER -- requirements
Module: glay_setup_resp_unpacker

Interface
REQ-001 Parameter DATA_WIDTH, default 512; memory response cacheline width in bits.
REQ-002 Parameter WORD_WIDTH, default 32; emitted word width; DATA_WIDTH SHALL be an integer multiple of it.
REQ-003 Parameter COUNTER_WIDTH, default 32; width of the word-count and word-index counters.
REQ-004 ap_clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-005 ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  single-cycle request to begin unpacking; sampled only in IDLE or DONE.
REQ-007 word_count  in  COUNTER_WIDTH  total words to emit; sampled in the start cycle.
REQ-008 resp_in_valid  in  1  cacheline available from the setup response FIFO.
REQ-009 resp_in_data  in  DATA_WIDTH  cacheline payload; word 0 in bits [WORD_WIDTH-1:0].
REQ-010 resp_in_ready  out  1  line accepted when resp_in_valid and resp_in_ready are both high.
REQ-011 word_out_valid  out  1  word_out_data and word_out_index are valid.
REQ-012 word_out_data  out  WORD_WIDTH  unpacked word.
REQ-013 word_out_index  out  COUNTER_WIDTH  running index of the emitted word, starting at 0.
REQ-014 word_out_ready  in  1  downstream accepts the word when word_out_valid and word_out_ready are both high.
REQ-015 busy  out  1  high in LOAD and SHIFT.
REQ-016 done  out  1  high in DONE; held until the next accepted start or reset.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-018 In IDLE or DONE, a start with word_count>0 SHALL latch word_count, clear the lane and index counters, and enter LOAD.
REQ-019 In IDLE or DONE, a start with word_count==0 SHALL enter DONE in the next cycle without consuming any line.
REQ-020 LOAD: resp_in_ready=1; on handshake, capture resp_in_data into the line register, set lane=0, enter SHIFT. Otherwise remain in LOAD.
REQ-021 SHIFT: resp_in_ready=0, word_out_valid=1, word_out_data=line[lane*WORD_WIDTH +: WORD_WIDTH], word_out_index=index.
REQ-022 On a SHIFT handshake, index+1 reaching the latched count SHALL enter DONE; any lanes left in the line are discarded.
REQ-023 Otherwise, on a SHIFT handshake at lane = DATA_WIDTH/WORD_WIDTH-1, the block SHALL enter LOAD.
REQ-024 Otherwise, on a SHIFT handshake, lane and index SHALL both increment and the state stays in SHIFT.
REQ-025 The first word SHALL be valid in the cycle after a line handshake; line-to-line overhead is exactly one LOAD cycle when resp_in_valid is already high.
REQ-026 With word_out_ready low, word_out_data, word_out_index and word_out_valid SHALL hold stable (no drop, no change).
REQ-027 start SHALL be ignored while busy; resp_in_valid SHALL be ignored outside LOAD.
REQ-028 Counters SHALL be unsigned COUNTER_WIDTH; the maximum count 2^COUNTER_WIDTH-1 SHALL complete without wrap.

Reset
REQ-029 Asserting ap_rst_n low, at any time including mid-line, SHALL immediately force IDLE, lane/index/count=0, resp_in_ready=0, word_out_valid=0, busy=0 and done=0.
REQ-030 word_out_data SHALL reset to 0, word_out_index to 0, and the line register to 0.
REQ-031 The first start after reset release SHALL be honoured in the cycle after ap_rst_n goes high.

Structure
REQ-032 The state enum (IDLE/LOAD/SHIFT/DONE) and a WORDS_PER_LINE constant SHALL live in GLAY_SETUP_PKG.
REQ-033 No sub-module; a single flat module containing the FSM, line register, lane counter and index counter.

Verification
REQ-034 word_count=20, two lines with word k = k, ready always high -> indices 0..19 with data 0..19; second line lanes 4..15 discarded; done after index 19; exactly 2 line handshakes.
REQ-035 word_count=16, word_out_ready toggling 1/0 each cycle -> 16 words, each held stable while stalled; no resp_in_ready after the first line handshake.
REQ-036 word_count=0 start -> done high 1 cycle later; resp_in_ready never asserted.
REQ-037 resp_in_valid delayed 10 cycles in LOAD -> resp_in_ready held high, word_out_valid low throughout, first word 1 cycle after the handshake.
REQ-038 ap_rst_n asserted at index 7 of 32 -> all outputs 0 asynchronously; a new start with word_count=3 yields indices 0..2 from a fresh line.
REQ-039 start pulsed while busy -> ignored, count unchanged; start in DONE with word_count=5 -> restarts, done drops, 5 words emitted.
